// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - Shared types, register offsets and CTRL bit layout for timer_dev.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } type_TIMER_STATE;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } type_TIMER_CTRL;

  // Only MODE=01 reloads; both 1x encodings behave as one-shot.
  function automatic logic is_autoreload(input logic [1:0] mode);
    return (mode == 2'b01);
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// rtl/timer_dev_if.sv - Data-memory bus slice seen by the timer, with irq back to CP0.
interface timer_dev_if;

  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (
    output sel, we, addr, din,
    input  dout, irq
  );

  modport slave (
    input  sel, we, addr, din,
    output dout, irq
  );

endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - Divides clk into one count tick per PRESCALE cycles.
module timer_prescaler #(
  parameter int PRESCALE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - Programmable down-counter on the DM bus driving CP0 HWInt[2].
// Defining TIMER_PRESCALE_EN slows counting to one tick per PRESCALE cycles.
module timer_dev
  import timer_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  timer_dev_if.slave bus
);

  type_TIMER_CTRL   r_ctrl;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic             r_irq_pend;
  type_TIMER_STATE  r_state;

  type_TIMER_STATE  w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_pend_set;
  logic             w_pend_clr;
  logic             w_en_clr;
  logic             w_tick;
  logic             w_wr_ctrl;
  logic             w_wr_preset;
  logic [31:0]      w_dout;

  assign w_wr_ctrl   = bus.sel && bus.we && (bus.addr == TMR_CTRL);
  assign w_wr_preset = bus.sel && bus.we && (bus.addr == TMR_PRESET);

`ifdef TIMER_PRESCALE_EN
  logic w_pre_clr;

  assign w_pre_clr = (r_state == LOAD) || !r_ctrl.en;

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_pre_clr),
    .tick  (w_tick)
  );
`else
  // Without the prescaler every cycle is a tick for any legal PRESCALE (>=1).
  assign w_tick = (PRESCALE >= 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_en_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_ctrl.en) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = CNT;
      end
      CNT: begin
        if (!r_ctrl.en) begin
          w_state_nxt = IDLE;
        end else if (w_tick) begin
          // PRESET=0 expires on the first tick just like PRESET=1; no wrap below zero.
          if (r_count <= CNT_W'(1)) begin
            w_count_nxt = '0;
            w_pend_set  = 1'b1;
            w_state_nxt = INT;
          end else begin
            w_count_nxt = r_count - CNT_W'(1);
          end
        end
      end
      INT: begin
        if (is_autoreload(r_ctrl.mode)) begin
          w_pend_clr  = 1'b1;
          w_state_nxt = LOAD;
        end else begin
          w_en_clr    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // Software writes take priority over the FSM's own EN clear and irq_pend updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= type_TIMER_CTRL'(bus.din[CTRL_IM:CTRL_EN]);
    end else if (w_en_clr) begin
      r_ctrl.en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_preset <= '0;
    end else if (w_wr_preset) begin
      r_preset <= bus.din[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_pend <= 1'b0;
    end else if (w_wr_ctrl || w_wr_preset) begin
      r_irq_pend <= 1'b0;
    end else if (w_pend_set) begin
      r_irq_pend <= 1'b1;
    end else if (w_pend_clr) begin
      r_irq_pend <= 1'b0;
    end
  end

  always_comb begin
    w_dout = '0;
    case (bus.addr)
      TMR_CTRL:   w_dout[CTRL_IM:CTRL_EN] = r_ctrl;
      TMR_PRESET: w_dout[CNT_W-1:0]       = r_preset;
      TMR_COUNT:  w_dout[CNT_W-1:0]       = r_count;
      default:    w_dout                  = '0;
    endcase
  end

  assign bus.dout = w_dout;
  assign bus.irq  = r_irq_pend && r_ctrl.im;

endmodule
